// File: rtl/if_queue_if.sv
// Fetch-queue bus: PC handshake, instruction-memory port and the decode-side head interface.
// The slave modport is the queue itself; the master modport is its environment (PC, ROM, decode).
interface if_queue_if;
    logic [15:0] pc_addr;
    logic        pc_en;
    logic        jump;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic [15:0] ir_out;
    logic [15:0] ir_pc;
    logic        ir_valid;
    logic        id_ready;
    logic [15:0] fetch_cnt;

    modport slave (
        input  pc_addr, jump, imem_data, id_ready,
        output pc_en, imem_addr, ir_out, ir_pc, ir_valid, fetch_cnt
    );

    modport master (
        output pc_addr, jump, imem_data, id_ready,
        input  pc_en, imem_addr, ir_out, ir_pc, ir_valid, fetch_cnt
    );
endinterface

// File: rtl/if_queue.sv
// Instruction fetch queue: drives the PC and a synchronous ROM, buffers up to two fetched
// instructions with their addresses, and hands them to decode at one per cycle.
module if_queue (
    input  logic      clk,
    input  logic      rst,
    if_queue_if.slave bus
);
    typedef enum logic {IDLE, RUN} state_t;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc;
    } entry_t;

    state_t      state, state_nx;
    entry_t      fifo [2];
    logic        rd_ptr, wr_ptr;
    logic [1:0]  count;
    logic        inflight;
    logic [15:0] inflight_pc;
    logic [15:0] fetch_cnt_q;
    logic [2:0]  occupancy;
    logic        ir_valid, pop, push, issue, pc_en;

    // Occupancy counts the ROM read already in flight, so a new fetch never overruns the FIFO.
    assign occupancy = {1'b0, count} + {2'b00, inflight};
    assign ir_valid  = (count != 2'd0) && !bus.jump;
    assign pop       = ir_valid && bus.id_ready;
    assign push      = inflight && !bus.jump;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_nx = state;
        issue    = 1'b0;
        pc_en    = 1'b0;
        case (state)
            IDLE: state_nx = RUN;
            RUN: begin
                issue = !bus.jump && ((occupancy < 3'd2) || pop);
                pc_en = issue || bus.jump;
            end
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: registers use non-blocking assignments so every update sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            count       <= 2'd0;
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
            inflight    <= 1'b0;
            inflight_pc <= 16'h0000;
            fetch_cnt_q <= 16'h0000;
        end else begin
            state    <= state_nx;
            inflight <= issue;
            if (issue)
                inflight_pc <= bus.pc_addr;

            // A redirect flushes everything fetched down the old path.
            if (state == RUN && bus.jump) begin
                count  <= 2'd0;
                rd_ptr <= 1'b0;
                wr_ptr <= 1'b0;
            end else begin
                if (push)
                    wr_ptr <= ~wr_ptr;
                if (pop)
                    rd_ptr <= ~rd_ptr;
                case ({push, pop})
                    2'b10:   count <= count + 2'd1;
                    2'b01:   count <= count - 2'd1;
                    default: count <= count;
                endcase
            end

            if (pop)
                fetch_cnt_q <= fetch_cnt_q + 16'd1;
        end
    end

    // NOTE: FIFO storage has no reset; count gates every read, so stale entries are never seen.
    always_ff @(posedge clk) begin
        if (push && !rst)
            fifo[wr_ptr] <= '{instr: bus.imem_data, pc: inflight_pc};
    end

    assign bus.imem_addr = bus.pc_addr;
    assign bus.ir_out    = fifo[rd_ptr].instr;
    assign bus.ir_pc     = fifo[rd_ptr].pc;
    assign bus.ir_valid  = ir_valid;
    assign bus.pc_en     = pc_en;
    assign bus.fetch_cnt = fetch_cnt_q;
endmodule
